button_event_queue: RTL and testbench

- Debounces the four game buttons and detects presses.
- Encodes each press as a colour code and buffers it in a small FIFO.
- The processor drains the FIFO with memory-mapped loads from dmem address 7.
- This is the processor-facing responder side of the button-poll interface: it replaces raw level polling with one event per physical press, consumed exactly once.

---
 rtl/button_event_queue.sv | 125 ++++++++++++
 tb/tb_button_event_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Debounced four-button press detector feeding a small colour-code FIFO that
// the processor drains one event per poll (dmem address 7).
module button_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned PTR_W           = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             red_button,
    input  logic             blue_button,
    input  logic             green_button,
    input  logic             yellow_button,
    input  logic             poll,
    output logic [31:0]      rdata,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Bit index equals colour code: red=0, blue=1, green=2, yellow=3.
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] db_cnt [4];

    logic [3:0]       rising;
    logic             press;
    logic [1:0]       press_colour;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             poll_d;
    logic             pop;
    logic             push;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Only the highest-priority simultaneous press is kept; the rest are
    // discarded silently (not an overflow).
    always_comb begin
        rising       = stable & ~stable_d;
        press        = |rising;
        press_colour = 2'd0;
        if (rising[0]) begin
            press_colour = 2'd0;
        end else if (rising[1]) begin
            press_colour = 2'd1;
        end else if (rising[2]) begin
            press_colour = 2'd2;
        end else if (rising[3]) begin
            press_colour = 2'd3;
        end
    end

    assign pop  = poll & ~poll_d & (count != '0);
    assign push = press & ((count != FULL_COUNT) | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            poll_d   <= 1'b0;
        end else begin
            poll_d <= poll;
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (press && !push) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= press_colour;
        end
    end

    assign rdata = (count != '0) ? {29'd0, mem[head], 1'b1} : 32'd0;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with DEBOUNCE_CYCLES=4, DEPTH=4.
module tb_button_event_queue;

    logic        clock;
    logic        reset;
    logic [3:0]  btn;
    logic        poll;
    logic [31:0] rdata;
    logic [2:0]  count;
    logic        overflow;

    int unsigned passes;
    int unsigned total;

    button_event_queue #(
        .DEBOUNCE_CYCLES (4),
        .DEPTH           (4),
        .PTR_W           (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .red_button    (btn[0]),
        .blue_button   (btn[1]),
        .green_button  (btn[2]),
        .yellow_button (btn[3]),
        .poll          (poll),
        .rdata         (rdata),
        .count         (count),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    // Hold one button long enough to debounce, then release and let it settle.
    task automatic press(input int unsigned idx);
        btn[idx] = 1'b1;
        tick(10);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    task automatic poll_once();
        poll = 1'b1;
        tick(1);
        poll = 1'b0;
        tick(1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        reset  = 1'b1;
        btn    = 4'b0000;
        poll   = 1'b0;
        tick(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick(2);

        // Single green press
        btn[2] = 1'b1;
        tick(20);
        btn[2] = 1'b0;
        tick(10);
        check("green_count", 32'(count), 32'd1);
        check("green_rdata", rdata, 32'h5);
        poll_once();
        check("green_pop_count", 32'(count), 32'd0);
        check("green_pop_rdata", rdata, 32'h0);

        // Bounce rejection on blue
        for (int i = 0; i < 15; i++) begin
            btn[1] = ~btn[1];
            tick(2);
        end
        btn[1] = 1'b0;
        tick(10);
        check("bounce_count", 32'(count), 32'd0);
        btn[1] = 1'b1;
        tick(10);
        btn[1] = 1'b0;
        tick(10);
        check("blue_hold_count", 32'(count), 32'd1);
        check("blue_hold_rdata", rdata, 32'h3);
        poll_once();
        check("blue_pop_count", 32'(count), 32'd0);

        // Ordering across pointer wrap
        press(0);
        press(3);
        press(1);
        press(2);
        check("order_count", 32'(count), 32'd4);
        check("order_rd0", rdata, 32'h1);
        poll_once();
        check("order_rd1", rdata, 32'h7);
        poll_once();
        check("order_rd2", rdata, 32'h3);
        poll_once();
        check("order_rd3", rdata, 32'h5);
        poll_once();
        check("order_empty", 32'(count), 32'd0);
        press(0);
        press(3);
        check("wrap_rd0", rdata, 32'h1);
        poll_once();
        check("wrap_rd1", rdata, 32'h7);
        poll_once();
        check("wrap_empty_rdata", rdata, 32'h0);

        // Polling while empty is a no-op
        poll_once();
        check("empty_poll_count", 32'(count), 32'd0);
        check("empty_poll_overflow", 32'(overflow), 32'd0);

        // Overflow: fifth press lost
        press(0);
        press(1);
        press(2);
        press(3);
        check("full_no_overflow", 32'(overflow), 32'd0);
        press(0);
        check("full_count", 32'(count), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_head", rdata, 32'h1);
        poll = 1'b1;
        tick(6);
        poll = 1'b0;
        tick(1);
        check("held_poll_count", 32'(count), 32'd3);
        check("held_poll_overflow", 32'(overflow), 32'd1);
        check("held_poll_rdata", rdata, 32'h3);
        poll_once();
        check("drain_rd1", rdata, 32'h5);
        poll_once();
        check("drain_rd2", rdata, 32'h7);
        poll_once();
        check("drain_empty", 32'(count), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Simultaneous red and yellow
        pulse_reset();
        check("rst_clears_overflow", 32'(overflow), 32'd0);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        tick(10);
        btn = 4'b0000;
        tick(10);
        check("simul_count", 32'(count), 32'd1);
        check("simul_rdata", rdata, 32'h1);
        check("simul_overflow", 32'(overflow), 32'd0);
        poll_once();

        // Reset mid-operation with blue mid-debounce
        press(2);
        press(3);
        check("pre_reset_count", 32'(count), 32'd2);
        btn[1] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        tick(6);
        check("post_rst_early", 32'(count), 32'd0);
        tick(1);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_rdata", rdata, 32'h3);
        tick(5);
        check("post_rst_hold", 32'(count), 32'd1);
        btn[1] = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
